// File: rtl/frac_baud_gen.sv
// Fractional-N baud generator: one phase accumulator yields the oversample tick and the bit tick.
// Optional MidTick output (mid-bit RX sample strobe) is built when FRAC_BAUD_MIDTICK_EN is defined.
module frac_baud_gen #(
  parameter int unsigned ClkFrequency = 100000000,
  parameter int unsigned Baud         = 115200,
  parameter int unsigned Oversample   = 16,
  parameter int unsigned AccWidth     = 20,
  parameter logic [63:0] DefaultInc   =
    (64'(Baud) * 64'(Oversample) * (64'd1 << AccWidth) + 64'(ClkFrequency / 2)) / 64'(ClkFrequency)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            resync,
  input  logic [AccWidth-1:0]             inc_in,
  input  logic                            inc_load,
  output logic [AccWidth-1:0]             inc,
  output logic                            OsTick,
  output logic                            BaudTick,
`ifdef FRAC_BAUD_MIDTICK_EN
  output logic                            MidTick,
`endif
  output logic [$clog2(Oversample)-1:0]   os_phase
);

  localparam int unsigned            PhW      = $clog2(Oversample);
  localparam logic [PhW-1:0]         PhLast   = PhW'(Oversample - 1);
  localparam logic [AccWidth-1:0]    IncReset = DefaultInc[AccWidth-1:0];

  logic [AccWidth-1:0] acc_q, acc_d;
  logic [AccWidth-1:0] inc_q, inc_d;
  logic [PhW-1:0]      phase_q, phase_d;
  logic                os_q, os_d;
  logic                baud_q, baud_d;
  logic [AccWidth:0]   sum;
  logic                carry;

  // The extra sum bit is the carry out of the accumulator: one carry is one OsTick.
  assign sum   = {1'b0, acc_q} + {1'b0, inc_q};
  assign carry = sum[AccWidth];

  always_comb begin
    acc_d   = acc_q;
    phase_d = phase_q;
    os_d    = 1'b0;
    baud_d  = 1'b0;
    // A load only affects later edges; this edge still accumulates with inc_q.
    inc_d   = inc_load ? inc_in : inc_q;
    if (resync) begin
      acc_d   = '0;
      phase_d = '0;
    end else if (en) begin
      acc_d  = sum[AccWidth-1:0];
      os_d   = carry;
      baud_d = carry && (phase_q == PhLast);
      if (carry) begin
        phase_d = phase_q + PhW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      inc_q   <= IncReset;
      phase_q <= '0;
      os_q    <= 1'b0;
      baud_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      phase_q <= phase_d;
      os_q    <= os_d;
      baud_q  <= baud_d;
    end
  end

`ifdef FRAC_BAUD_MIDTICK_EN
  localparam logic [PhW-1:0] PhMid = PhW'(Oversample / 2 - 1);
  logic mid_q, mid_d;

  always_comb begin
    mid_d = 1'b0;
    if (!resync && en) begin
      mid_d = carry && (phase_q == PhMid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mid_q <= 1'b0;
    end else begin
      mid_q <= mid_d;
    end
  end

  assign MidTick = mid_q;
`endif

  assign inc      = inc_q;
  assign OsTick   = os_q;
  assign BaudTick = baud_q;
  assign os_phase = phase_q;

endmodule
